// File: rtl/calc_seq.sv
// Keypad-driven decimal calculator core. It supports add, sub and shift-add multiply with
// result chaining, and streams each operand or result one digit per cycle with leading-zero blanking.
module calc_seq #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned W      = 27
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [3:0]                cmd,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  output logic [1:0]                status,
  output logic [2:0]                state,
  output logic [3:0]                data,
  output logic [$clog2(DIGITS)-1:0] pos,
  output logic                      disp_valid
);
  localparam int unsigned PosW = $clog2(DIGITS);
  localparam int unsigned CntW = $clog2(W + 1);

  function automatic logic [2*W-1:0] pow10(input int unsigned n);
    logic [2*W-1:0] p;
    p = (2*W)'(1);
    for (int unsigned i = 0; i < n; i++) p = p * (2*W)'(10);
    return p;
  endfunction

  localparam logic [2*W-1:0]  Limit   = pow10(DIGITS);
  localparam logic [W-1:0]    FullOp  = W'(pow10(DIGITS - 1));
  localparam logic [PosW-1:0] PosLast = PosW'(DIGITS - 1);
  localparam logic [W-1:0]    Ten     = W'(10);

  localparam logic [3:0] CmdAdd = 4'd10, CmdSub = 4'd11, CmdMul = 4'd12;
  localparam logic [3:0] CmdClr = 4'd13, CmdEq = 4'd14, CmdBsp = 4'd15;
  localparam logic [1:0] OpSub = 2'd1, OpMul = 2'd2;

  typedef enum logic [2:0] {
    StEntryA = 3'd0,
    StEntryB = 3'd1,
    StOpWait = 3'd2,
    StCalc   = 3'd3,
    StError  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    reg_a_q, reg_a_d, reg_b_q, reg_b_d, acc_q, acc_d, shown_q, shown_d;
  logic [2*W-1:0]  prod_q, prod_d;
  logic [1:0]      op_q, op_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            disp_valid_q, disp_valid_d;
  logic [PosW-1:0] pos_q, pos_d;
  logic [3:0]      data_q, data_d;

  logic           accept, is_digit, is_op, do_clear, print_go, calc_err;
  logic [W-1:0]   print_val, calc_res, edit_val, edit_app, edit_bsp;
  logic [2*W-1:0] sum_wide;
  logic [W:0]     mul_sum;

  always_comb begin
    accept   = cmd_valid && cmd_ready;
    is_digit = cmd <= 4'd9;
    is_op    = cmd inside {CmdAdd, CmdSub, CmdMul};
    edit_val = (state_q == StEntryB) ? reg_b_q : reg_a_q;
    edit_app = edit_val * Ten + W'(cmd);
    edit_bsp = edit_val / Ten;
    sum_wide = (2*W)'(reg_a_q) + (2*W)'(reg_b_q);
    // Right-shifting multiplier: upper half accumulates, lower half drains regB LSB first.
    mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, reg_a_q} : '0);
    unique case (op_q)
      OpSub: begin
        calc_res = reg_a_q - reg_b_q;
        calc_err = reg_a_q < reg_b_q;
      end
      OpMul: begin
        calc_res = prod_q[W-1:0];
        calc_err = prod_q >= Limit;
      end
      default: begin
        calc_res = sum_wide[W-1:0];
        calc_err = sum_wide >= Limit;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    reg_a_d   = reg_a_q;
    reg_b_d   = reg_b_q;
    acc_d     = acc_q;
    prod_d    = prod_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    do_clear  = 1'b0;
    print_go  = 1'b0;
    print_val = '0;
    unique case (state_q)
      StEntryA, StEntryB: begin
        if (accept) begin
          if (is_digit || cmd == CmdBsp) begin
            // A full operand swallows further digits silently.
            if (!is_digit || edit_val < FullOp) begin
              print_go  = 1'b1;
              print_val = is_digit ? edit_app : edit_bsp;
              if (state_q == StEntryA) reg_a_d = print_val;
              else                     reg_b_d = print_val;
            end
          end else if (cmd == CmdClr) begin
            do_clear = 1'b1;
          end else if (is_op && state_q == StEntryA) begin
            op_d      = 2'(cmd - CmdAdd);
            reg_b_d   = '0;
            state_d   = StEntryB;
            print_go  = 1'b1;
            print_val = reg_a_q;
          end else if (cmd == CmdEq && state_q == StEntryB) begin
            prod_d  = {{W{1'b0}}, reg_b_q};
            cnt_d   = '0;
            state_d = StCalc;
          end
        end
      end
      StOpWait: begin
        if (accept) begin
          if (is_digit) begin
            reg_a_d   = W'(cmd);
            state_d   = StEntryA;
            print_go  = 1'b1;
            print_val = W'(cmd);
          end else if (is_op) begin
            op_d      = 2'(cmd - CmdAdd);
            reg_b_d   = '0;
            state_d   = StEntryB;
            print_go  = 1'b1;
            print_val = reg_a_q;
          end else if (cmd == CmdClr) begin
            do_clear = 1'b1;
          end
        end
      end
      StCalc: begin
        if (op_q == OpMul && cnt_q != CntW'(W)) begin
          prod_d = {mul_sum, prod_q[W-1:1]};
          cnt_d  = cnt_q + 1'b1;
        end else if (calc_err) begin
          state_d = StError;
        end else begin
          acc_d     = calc_res;
          reg_a_d   = calc_res;
          reg_b_d   = '0;
          state_d   = StOpWait;
          print_go  = 1'b1;
          print_val = calc_res;
        end
      end
      StError: begin
        if (accept && cmd == CmdClr) do_clear = 1'b1;
      end
      default: state_d = StEntryA;
    endcase

    if (do_clear) begin
      reg_a_d   = '0;
      reg_b_d   = '0;
      acc_d     = '0;
      prod_d    = '0;
      op_d      = '0;
      state_d   = StEntryA;
      print_go  = 1'b1;
      print_val = '0;
    end

    disp_valid_d = disp_valid_q;
    pos_d        = pos_q;
    data_d       = data_q;
    shown_d      = shown_q;
    if (print_go) begin
      disp_valid_d = 1'b1;
      pos_d        = '0;
      data_d       = 4'(print_val % Ten);
      shown_d      = print_val / Ten;
    end else if (disp_valid_q) begin
      if (pos_q == PosLast) begin
        disp_valid_d = 1'b0;
      end else begin
        pos_d   = pos_q + 1'b1;
        data_d  = (shown_q == '0) ? 4'hF : 4'(shown_q % Ten);
        shown_d = shown_q / Ten;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StEntryA;
      reg_a_q      <= '0;
      reg_b_q      <= '0;
      acc_q        <= '0;
      prod_q       <= '0;
      op_q         <= '0;
      cnt_q        <= '0;
      shown_q      <= '0;
      disp_valid_q <= 1'b0;
      pos_q        <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      reg_a_q      <= reg_a_d;
      reg_b_q      <= reg_b_d;
      acc_q        <= acc_d;
      prod_q       <= prod_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      shown_q      <= shown_d;
      disp_valid_q <= disp_valid_d;
      pos_q        <= pos_d;
      data_q       <= data_d;
    end
  end

  assign state      = state_q;
  assign data       = data_q;
  assign pos        = pos_q;
  assign disp_valid = disp_valid_q;
  assign cmd_ready  = !disp_valid_q && (state_q inside {StEntryA, StEntryB, StOpWait, StError});

  always_comb begin
    if (disp_valid_q)             status = 2'b11;
    else if (state_q == StCalc)   status = 2'b01;
    else if (state_q == StError)  status = 2'b00;
    else                          status = 2'b10;
  end

endmodule

// File: doc/calc_seq.md
# calc_seq

Parametrised sequential decimal calculator core: the next generation of the team's four-bit-command calculator FSM. It accepts keypad commands over a valid/ready handshake and supports add, subtract and multi-cycle shift-add multiply. Results chain into the next operation, and overflow or a negative result raises an error. After every accepted command the current operand or result is streamed to the display controller one decimal digit per cycle, with leading-zero blanking.

## Interface
Parameters:
- DIGITS, 8: number of decimal display digits and the maximum operand length.
- W, 27: operand/result width in bits; it must satisfy 2^W > 10^DIGITS − 1.

Ports:
- clock  in  1  rising-edge system clock
- reset  in  1  reset, asynchronous, active-high
- cmd  in  4  command code: 0–9 digit, 10 add, 11 sub, 12 mul, 13 clear, 14 '=', 15 backspace
- cmd_valid  in  1  cmd present this cycle
- cmd_ready  out  1  core can accept a cmd this cycle
- status  out  2  00 error, 01 busy (calculating), 10 ready, 11 printing
- state  out  3  FSM state code, exported for debug
- data  out  4  BCD digit; 4'hF means blank
- pos  out  $clog2(DIGITS)  digit position, 0 = least significant
- disp_valid  out  1  data/pos valid this cycle

## Operation
- A cmd is accepted when cmd_valid && cmd_ready. cmd_ready = 1 only in ENTRY_A, OP_WAIT, ENTRY_B or ERROR, and only while no print is in progress.
- Registers:
  - regA, regB, acc: W bits each; prod: 2W bits.
  - op: 2 bits.
  - shown: the value being printed.
- FSM states: ENTRY_A=0, ENTRY_B=1, OP_WAIT=2, CALC=3, ERROR=4.
- ENTRY_A:
  - Digit d: regA ← regA·10+d, unless regA ≥ 10^(DIGITS−1); in that case the digit is consumed and ignored, with no print.
  - Backspace: regA ← regA/10.
  - Op (10–12): latch op, regB ← 0, go to ENTRY_B.
  - '=': ignored.
  - Clear: zero all registers.
- ENTRY_B: the same digit and backspace rules, applied to regB.
  - '=': go to CALC.
  - A further op: ignored.
  - Clear: go to ENTRY_A with everything zeroed.
- CALC (cmd_ready = 0, status = 01):
  - add: acc ← regA+regB in 1 cycle.
  - sub: acc ← regA−regB in 1 cycle.
  - mul: W-cycle shift-add over the bits of regB, LSB first, into prod; then acc ← prod[W−1:0].
  - Error if the add result ≥ 10^DIGITS, if regA < regB on sub, or if prod ≥ 10^DIGITS on mul. On error: go to ERROR, print nothing.
  - Otherwise: regA ← acc, regB ← 0, print acc, go to OP_WAIT.
- OP_WAIT (chaining):
  - Op: latch op, go to ENTRY_B; regA keeps the previous result.
  - Digit: regA ← d, go to ENTRY_A.
  - Backspace and '=': ignored.
  - Clear: go to ENTRY_A with everything zeroed.
- ERROR: status = 00. Only clear is acted on; it zeroes everything, prints 0 and goes to ENTRY_A. All other cmds are consumed and ignored.
- Print:
  - Triggered by every accepted cmd that changes or confirms an operand (digit, backspace, op, clear), and by CALC completion.
  - shown = the operand being edited. On an op this is regA; on clear it is 0.
  - The print runs for DIGITS cycles: pos = 0..DIGITS−1, data = shown%10, then shown ← shown/10.
  - Blanking: positions above the most significant non-zero digit output 4'hF. Position 0 always shows a digit, so zero prints as "0".

## Timing
- Reset values:
  - status = 10, cmd_ready = 1, state = ENTRY_A.
  - data = 0, pos = 0, disp_valid = 0.
  - regA, regB, acc, prod and op = 0.
- Reset asserted mid-print or mid-multiply aborts immediately to the reset values. No partial digits follow reset deassertion.
- Cmd accepted at edge N:
  - The register update is visible after edge N.
  - disp_valid = 1 with status = 11 for cycles N+1..N+DIGITS.
  - status returns to 10 and cmd_ready to 1 in cycle N+DIGITS+1.
- '=' accepted at edge N:
  - add/sub: status = 01 in cycle N+1; print in N+2..N+DIGITS+1.
  - mul: status = 01 for W+1 cycles (N+1..N+W+1); print follows.
- A consumed-but-ignored cmd keeps cmd_ready = 1 in the following cycle and produces no print.
- cmd_valid while cmd_ready = 0 is not accepted. The source must hold cmd until it is.

## Test plan
- Reset, then 1,2,3 each followed by the print window. The last print shows pos0..2 = 3,2,1 and pos3..7 = F. Then backspace prints 2,1,F….
- 1,2, add, 3,4, '=': status 01 for 1 cycle, then prints 46 (6,4,F…), state = OP_WAIT. Then sub, 6, '=' prints 40.
- 1,2,3,4, mul, 5,6,7, '=': status 01 for 28 cycles, then prints 699678.
- 9 entered 8 times, add, 1, '=': status goes to 00 and no print occurs. Digit 5 is ignored; clear prints "0" and returns status to 10.
- 3, sub, 5, '=': goes to ERROR (negative result). 9 digits entered: the 9th is ignored with no print, and regA = 12345678.
- Reset asserted at the 10th cycle of a multiply: all outputs reach their reset values the same cycle, with no disp_valid afterwards. Holding cmd_valid during a print delays acceptance until cmd_ready rises.
